serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_ctrl.sv | 118 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder: one full adder, one bit per clock, LSB first
// Operands shift right through the adder; the sum enters the result register from the MSB side.

module one_bit_full_adder (
   input  logic A,
   input  logic B,
   input  logic C_in,
   output logic C_out,
   output logic S
);
   assign S     = A ^ B ^ C_in;
   assign C_out = (A & B) | (C_in & (A ^ B));
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             C_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             C_out
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_next;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_s, fa_c;
   logic             load, last_bit;

   one_bit_full_adder u_fa (
      .A     (a_sh[0]),
      .B     (b_sh[0]),
      .C_in  (carry),
      .C_out (fa_c),
      .S     (fa_s)
   );

   generate
      if (WIDTH == 1) begin : g_res1
         assign res_next = fa_s;
      end else begin : g_resn
         assign res_next = {fa_s, res_sh[WIDTH-1:1]};
      end
   endgenerate

   always_comb begin
      state_next = state;
      load       = 1'b0;
      last_bit   = (cnt == LAST);
      case (state)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            if (last_bit) state_next = DONE;
         end
         DONE: begin
            // Start here chains straight into the next addition.
            if (start) begin
               load       = 1'b1;
               state_next = RUN;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         S      <= '0;
         C_out  <= 1'b0;
      end else if (load) begin
         a_sh  <= A;
         b_sh  <= B;
         carry <= C_in;
         cnt   <= '0;
      end else if (state == RUN) begin
         a_sh   <= a_sh >> 1;
         b_sh   <= b_sh >> 1;
         carry  <= fa_c;
         res_sh <= res_next;
         cnt    <= cnt + 1'b1;
         if (last_bit) begin
            S     <= res_next;
            C_out <= fa_c;
         end
      end
   end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - directed self-checking bench for serial_adder_ctrl
// Inputs change and outputs are sampled on the falling edge.

module tb_serial_adder_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] a = '0, b = '0;
   logic       c_in = 1'b0;
   logic       busy, done, c_out;
   logic [7:0] s;

   logic       start1 = 1'b0, a1 = 1'b0, b1 = 1'b0, c_in1 = 1'b0;
   logic       busy1, done1, c_out1;
   logic [0:0] s1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .C_in(c_in),
      .busy(busy), .done(done), .S(s), .C_out(c_out)
   );

   serial_adder_ctrl #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1), .C_in(c_in1),
      .busy(busy1), .done(done1), .S(s1), .C_out(c_out1)
   );

   task automatic launch(input logic [7:0] av, input logic [7:0] bv, input logic cv);
      @(negedge clk);
      a = av; b = bv; c_in = cv; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int busy_cyc, output bit ok);
      ok = 1'b0;
      busy_cyc = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) begin
            ok = 1'b1;
            break;
         end
         if (busy) busy_cyc++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      @(negedge clk);
      start = 1'b1; a = 8'hFF; b = 8'hFF; start1 = 1'b1;
      @(negedge clk);
      total++; if ({busy, done, s, c_out} !== 11'h0) begin bad++; $display("FAIL reset_outs got=%h want=0", {busy, done, s, c_out}); end
      start = 1'b0; start1 = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL reset_start_ignored got=%b want=00", {busy, done}); end
      total++; if ({busy1, done1, s1, c_out1} !== 4'h0) begin bad++; $display("FAIL reset_w1 got=%h want=0", {busy1, done1, s1, c_out1}); end
   endtask

   task automatic test_zero;
      int n; bit ok;
      launch(8'h00, 8'h00, 1'b0);
      wait_done(n, ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL zero_done_timeout got=%b want=1", ok); end
      total++; if (n !== 8) begin bad++; $display("FAIL zero_busy_cycles got=%0d want=8", n); end
      total++; if ({c_out, s} !== 9'h000) begin bad++; $display("FAIL zero_sum got=%h want=000", {c_out, s}); end
      @(negedge clk);
      total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL zero_single_pulse got=%b want=00", {busy, done}); end
   endtask

   task automatic test_carry;
      int n; bit ok;
      launch(8'hFF, 8'h01, 1'b0);
      wait_done(n, ok);
      total++; if (ok !== 1'b1 || {c_out, s} !== 9'h100) begin bad++; $display("FAIL carry_ff_01 got=%b/%h want=1/100", ok, {c_out, s}); end
      launch(8'hFF, 8'hFF, 1'b1);
      wait_done(n, ok);
      total++; if (ok !== 1'b1 || {c_out, s} !== 9'h1FF) begin bad++; $display("FAIL carry_ff_ff_1 got=%b/%h want=1/1ff", ok, {c_out, s}); end
   endtask

   task automatic test_hold;
      int n; bit ok; int changes;
      launch(8'hA5, 8'h5A, 1'b1);
      wait_done(n, ok);
      total++; if (ok !== 1'b1 || {c_out, s} !== 9'h100) begin bad++; $display("FAIL hold_a5_5a got=%b/%h want=1/100", ok, {c_out, s}); end
      changes = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if ({c_out, s} !== 9'h100 || busy !== 1'b0 || done !== 1'b0) changes++;
      end
      total++; if (changes !== 0) begin bad++; $display("FAIL hold_idle got=%0d changes want=0", changes); end
   endtask

   task automatic test_start_during_run;
      int n; bit ok; int extra;
      launch(8'h12, 8'h34, 1'b0);
      @(negedge clk);
      @(negedge clk);
      total++; if ({c_out, s} !== 9'h100) begin bad++; $display("FAIL run_holds_prev got=%h want=100", {c_out, s}); end
      a = 8'hFF; b = 8'hFF; c_in = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(n, ok);
      total++; if (ok !== 1'b1 || n !== 5) begin bad++; $display("FAIL ignore_start_timing got=%b/%0d want=1/5", ok, n); end
      total++; if ({c_out, s} !== 9'h046) begin bad++; $display("FAIL ignore_start_sum got=%h want=046", {c_out, s}); end
      extra = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done || busy) extra++;
      end
      total++; if (extra !== 0) begin bad++; $display("FAIL ignore_start_extra got=%0d want=0", extra); end
   endtask

   task automatic test_back_to_back;
      int n; bit ok;
      launch(8'h01, 8'h01, 1'b0);
      wait_done(n, ok);
      total++; if (ok !== 1'b1 || {c_out, s} !== 9'h002) begin bad++; $display("FAIL b2b_first got=%b/%h want=1/002", ok, {c_out, s}); end
      a = 8'h03; b = 8'h04; c_in = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      total++; if ({busy, done} !== 2'b10) begin bad++; $display("FAIL b2b_no_bubble got=%b want=10", {busy, done}); end
      wait_done(n, ok);
      total++; if (ok !== 1'b1 || n !== 8) begin bad++; $display("FAIL b2b_timing got=%b/%0d want=1/8", ok, n); end
      total++; if ({c_out, s} !== 9'h007) begin bad++; $display("FAIL b2b_sum got=%h want=007", {c_out, s}); end
   endtask

   task automatic test_reset_mid_run;
      int n; bit ok; int dones;
      launch(8'h55, 8'h22, 1'b0);
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      total++; if ({busy, done, s, c_out} !== 11'h0) begin bad++; $display("FAIL midrun_reset got=%h want=0", {busy, done, s, c_out}); end
      @(negedge clk);
      rst = 1'b0;
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done || busy) dones++;
      end
      total++; if (dones !== 0) begin bad++; $display("FAIL midrun_no_done got=%0d want=0", dones); end
      launch(8'h10, 8'h20, 1'b0);
      wait_done(n, ok);
      total++; if (ok !== 1'b1 || n !== 8 || {c_out, s} !== 9'h030) begin bad++; $display("FAIL after_reset_add got=%b/%0d/%h want=1/8/030", ok, n, {c_out, s}); end
   endtask

   task automatic test_width1;
      int n; bit ok;
      @(negedge clk);
      a1 = 1'b1; b1 = 1'b1; c_in1 = 1'b1; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      total++; if ({busy1, done1} !== 2'b10) begin bad++; $display("FAIL w1_run got=%b want=10", {busy1, done1}); end
      @(negedge clk);
      total++; if ({busy1, done1, c_out1, s1} !== 4'b0111) begin bad++; $display("FAIL w1_result got=%b want=0111", {busy1, done1, c_out1, s1}); end
      @(negedge clk);
      total++; if ({busy1, done1} !== 2'b00) begin bad++; $display("FAIL w1_idle got=%b want=00", {busy1, done1}); end
   endtask

   initial begin
      test_reset();
      test_zero();
      test_carry();
      test_hold();
      test_start_during_run();
      test_back_to_back();
      test_reset_mid_run();
      test_width1();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
